// File: rtl/exec_unit_if.sv
// Execute-stage bus between decode/control and the execute unit.
// The master (decode stage) issues operations; the slave (exec_unit)
// returns the register-file write port, status flags and busy.
interface exec_unit_if #(
  parameter int WIDTH = 24,
  parameter int AW    = 2
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [AW-1:0]    dst;
  logic             busy;
  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic             zero;
  logic             carry;
  logic             illegal;

  modport master (
    output start, op, a, b, dst,
    input  busy, wr_en, wr_addr, wr_data, zero, carry, illegal
  );

  modport slave (
    input  start, op, a, b, dst,
    output busy, wr_en, wr_addr, wr_data, zero, carry, illegal
  );
endinterface

// File: rtl/exec_unit.sv
// exec_unit: execute stage of the 24-bit datapath.
// Single-cycle ADD/SUB/AND/OR/XOR/SHL/SHR, iterative shift-add MUL.
// Optional multiplier: define EXEC_MUL_EN to build it; without it,
// op 111 raises a one-cycle illegal pulse and nothing is written.
module exec_unit #(
  parameter int WIDTH = 24,
  parameter int AW    = 2
) (
  input logic        clk,
  input logic        reset,
  exec_unit_if.slave bus
);

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_SHL = 3'd5;
  localparam logic [2:0] OP_SHR = 3'd6;
  localparam logic [2:0] OP_MUL = 3'd7;

  // MUL is simply never entered when the multiplier is not built
  typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, DONE = 2'd2} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] wrData_q, wrData_d;
  logic [AW-1:0]    wrAddr_q, wrAddr_d;
  logic             zero_q, zero_d;
  logic             carry_q, carry_d;
  logic             illegal_q, illegal_d;

  logic [WIDTH-1:0] aluResult;
  logic             aluCarry;
  logic [4:0]       shamt;

`ifdef EXEC_MUL_EN
  localparam int CNT_W = $clog2(WIDTH);
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] product_q, product_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [AW-1:0]    dst_q, dst_d;
  logic [WIDTH-1:0] productSum;
`endif

  assign shamt = bus.b[4:0];

  // Single-cycle ALU straight from the accept-cycle operands
  always_comb begin
    aluResult = '0;
    aluCarry  = 1'b0;
    unique case (bus.op)
      OP_ADD: {aluCarry, aluResult} = {1'b0, bus.a} + {1'b0, bus.b};
      OP_SUB: {aluCarry, aluResult} = {1'b0, bus.a} - {1'b0, bus.b};
      OP_AND: aluResult = bus.a & bus.b;
      OP_OR:  aluResult = bus.a | bus.b;
      OP_XOR: aluResult = bus.a ^ bus.b;
      OP_SHL: aluResult = ({27'd0, shamt} >= 32'(WIDTH)) ? '0 : (bus.a << shamt);
      OP_SHR: aluResult = ({27'd0, shamt} >= 32'(WIDTH)) ? '0 : (bus.a >> shamt);
      default: aluResult = '0;
    endcase
  end

  // Next-state logic: accept in IDLE, iterate in MUL, write back in DONE
  always_comb begin
    state_d   = state_q;
    wrData_d  = wrData_q;
    wrAddr_d  = wrAddr_q;
    zero_d    = zero_q;
    carry_d   = carry_q;
    illegal_d = 1'b0;
`ifdef EXEC_MUL_EN
    mcand_d    = mcand_q;
    mplier_d   = mplier_q;
    product_d  = product_q;
    cnt_d      = cnt_q;
    dst_d      = dst_q;
    productSum = product_q + (mplier_q[0] ? mcand_q : '0);
`endif
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (bus.op == OP_MUL) begin
`ifdef EXEC_MUL_EN
            mcand_d   = bus.a;
            mplier_d  = bus.b;
            product_d = '0;
            cnt_d     = CNT_W'(WIDTH - 1);
            dst_d     = bus.dst;
            state_d   = MUL;
`else
            illegal_d = 1'b1;
`endif
          end else begin
            wrData_d = aluResult;
            wrAddr_d = bus.dst;
            zero_d   = (aluResult == '0);
            carry_d  = aluCarry;
            state_d  = DONE;
          end
        end
      end
      MUL: begin
`ifdef EXEC_MUL_EN
        product_d = productSum;
        mcand_d   = mcand_q << 1;
        mplier_d  = mplier_q >> 1;
        if (cnt_q == '0) begin
          wrData_d = productSum;
          wrAddr_d = dst_q;
          zero_d   = (productSum == '0);
          carry_d  = 1'b0;
          state_d  = DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
`else
        state_d = IDLE;
`endif
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any op in flight
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      wrData_q  <= '0;
      wrAddr_q  <= '0;
      zero_q    <= 1'b0;
      carry_q   <= 1'b0;
      illegal_q <= 1'b0;
`ifdef EXEC_MUL_EN
      mcand_q   <= '0;
      mplier_q  <= '0;
      product_q <= '0;
      cnt_q     <= '0;
      dst_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      wrData_q  <= wrData_d;
      wrAddr_q  <= wrAddr_d;
      zero_q    <= zero_d;
      carry_q   <= carry_d;
      illegal_q <= illegal_d;
`ifdef EXEC_MUL_EN
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      product_q <= product_d;
      cnt_q     <= cnt_d;
      dst_q     <= dst_d;
`endif
    end
  end

  assign bus.busy    = (state_q != IDLE);
  assign bus.wr_en   = (state_q == DONE);
  assign bus.wr_addr = wrAddr_q;
  assign bus.wr_data = wrData_q;
  assign bus.zero    = zero_q;
  assign bus.carry   = carry_q;
  assign bus.illegal = illegal_q;

endmodule

// File: tb/tb_exec_unit.sv
// Self-checking bench for exec_unit: directed corner cases followed by
// randomized operations, compared against an arithmetic reference model.
module tb_exec_unit;

  localparam int W  = 24;
  localparam int AW = 2;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_SHL = 3'd5;
  localparam logic [2:0] OP_SHR = 3'd6;
  localparam logic [2:0] OP_MUL = 3'd7;

  logic clk;
  logic reset;

  exec_unit_if #(.WIDTH(W), .AW(AW)) bus ();

  exec_unit #(.WIDTH(W), .AW(AW)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int compareCount = 0;
  int failCount    = 0;

  // Architectural state the bench expects the DUT to hold
  logic [W-1:0]  expData;
  logic [AW-1:0] expAddr;
  logic          expZero;
  logic          expCarry;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compareCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Reference model: plain unsigned arithmetic on wide integers
  function automatic void refModel(input logic [2:0] op, input logic [W-1:0] a,
                                   input logic [W-1:0] b, output logic [W-1:0] res,
                                   output logic cy);
    longint unsigned ua, ub, full, sh;
    ua = 64'(a);
    ub = 64'(b);
    sh = ub % 32;
    full = 0;
    cy = 1'b0;
    case (op)
      OP_ADD: begin full = ua + ub; cy = (full >= (64'd1 << W)); end
      OP_SUB: begin full = ua - ub; cy = (ua < ub); end
      OP_AND: full = ua & ub;
      OP_OR:  full = ua | ub;
      OP_XOR: full = ua ^ ub;
      OP_SHL: full = (sh >= W) ? 0 : ua * (64'd1 << sh);
      OP_SHR: full = (sh >= W) ? 0 : ua / (64'd1 << sh);
      default: full = ua * ub;
    endcase
    res = W'(full % (64'd1 << W));
  endfunction

  task automatic checkHeld(input string prefix);
    checkOutput({prefix, ".wr_data"}, 32'(bus.wr_data), 32'(expData));
    checkOutput({prefix, ".wr_addr"}, 32'(bus.wr_addr), 32'(expAddr));
    checkOutput({prefix, ".zero"},    32'(bus.zero),    32'(expZero));
    checkOutput({prefix, ".carry"},   32'(bus.carry),   32'(expCarry));
  endtask

  // Present one request for a single clock, then scramble the operand pins
  task automatic applyStimulus(input logic [2:0] op, input logic [W-1:0] a,
                               input logic [W-1:0] b, input logic [AW-1:0] dst);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    bus.dst   = dst;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.op    = 3'($urandom);
    bus.a     = W'($urandom);
    bus.b     = W'($urandom);
    bus.dst   = AW'($urandom);
  endtask

  task automatic pokeStart();
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = 3'($urandom_range(0, 6));
    bus.a     = W'($urandom);
    bus.b     = W'($urandom);
    bus.dst   = AW'($urandom);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  // One full operation: accept, latency checks, write-back, return to idle
  task automatic runOp(input logic [2:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [AW-1:0] dst, input bit poke);
    logic [W-1:0] res;
    logic         cy;
    refModel(op, a, b, res, cy);
    checkOutput("pre.busy", 32'(bus.busy), 0);
    applyStimulus(op, a, b, dst);
    if (op == OP_MUL) begin
`ifdef EXEC_MUL_EN
      for (int c = 1; c <= W; c++) begin
        checkOutput("mul.busy", 32'(bus.busy), 1);
        checkOutput("mul.wr_en", 32'(bus.wr_en), 0);
        checkOutput("mul.wr_data_held", 32'(bus.wr_data), 32'(expData));
        if (poke && c == 5) pokeStart();
        else begin @(posedge clk); #1; end
      end
`else
      checkOutput("illegal.pulse", 32'(bus.illegal), 1);
      checkOutput("illegal.wr_en", 32'(bus.wr_en), 0);
      checkOutput("illegal.busy", 32'(bus.busy), 0);
      checkHeld("illegal");
      @(posedge clk);
      #1;
      checkOutput("illegal.clear", 32'(bus.illegal), 0);
      checkOutput("illegal.wr_en2", 32'(bus.wr_en), 0);
      return;
`endif
    end
    expData  = res;
    expAddr  = dst;
    expZero  = (res == '0);
    expCarry = cy;
    checkOutput("done.wr_en", 32'(bus.wr_en), 1);
    checkOutput("done.busy", 32'(bus.busy), 1);
    checkOutput("done.illegal", 32'(bus.illegal), 0);
    checkHeld("done");
    if (poke && op != OP_MUL) pokeStart();
    else begin @(posedge clk); #1; end
    checkOutput("after.wr_en", 32'(bus.wr_en), 0);
    checkOutput("after.busy", 32'(bus.busy), 0);
    checkHeld("after");
  endtask

  initial begin
    $display("[TB] exec_unit bench starting");
    reset     = 1'b0;
    bus.start = 1'b0;
    bus.op    = '0;
    bus.a     = '0;
    bus.b     = '0;
    bus.dst   = '0;
    expData   = '0;
    expAddr   = '0;
    expZero   = 1'b0;
    expCarry  = 1'b0;

    // Reset held with random activity on the inputs
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.start = 1'($urandom);
      bus.op    = 3'($urandom);
      bus.a     = W'($urandom);
      bus.b     = W'($urandom);
      bus.dst   = AW'($urandom);
    end
    #1;
    checkOutput("reset.busy", 32'(bus.busy), 0);
    checkOutput("reset.wr_en", 32'(bus.wr_en), 0);
    checkOutput("reset.illegal", 32'(bus.illegal), 0);
    checkHeld("reset");
    @(negedge clk);
    bus.start = 1'b0;
    reset     = 1'b1;

    // Directed corner cases
    runOp(OP_ADD, 24'hFFFFFF, 24'h000001, 2'd2, 1'b0);
    runOp(OP_SUB, 24'd5, 24'd7, 2'd1, 1'b0);
    runOp(OP_SUB, 24'd7, 24'd7, 2'd1, 1'b1);
    runOp(OP_SHL, 24'h000001, 24'd23, 2'd0, 1'b0);
    runOp(OP_SHR, 24'h800000, 24'd24, 2'd3, 1'b0);
    runOp(OP_SHL, 24'hFFFFFF, 24'd31, 2'd2, 1'b0);
    runOp(OP_AND, 24'hF0F0F0, 24'h3C3C3C, 2'd1, 1'b0);
    runOp(OP_OR,  24'hF00000, 24'h00000F, 2'd3, 1'b0);
    runOp(OP_XOR, 24'hA5A5A5, 24'hA5A5A5, 2'd0, 1'b0);

`ifdef EXEC_MUL_EN
    runOp(OP_MUL, 24'd1234, 24'd5678, 2'd3, 1'b1);
    runOp(OP_MUL, 24'hFFFFFF, 24'd2, 2'd1, 1'b0);

    // Reset in the middle of a multiply aborts it without a write
    applyStimulus(OP_MUL, 24'd99, 24'd77, 2'd2);
    for (int c = 1; c < 10; c++) begin @(posedge clk); #1; end
    #2;
    reset = 1'b0;
    #1;
    expData  = '0;
    expAddr  = '0;
    expZero  = 1'b0;
    expCarry = 1'b0;
    checkOutput("midreset.busy", 32'(bus.busy), 0);
    checkOutput("midreset.wr_en", 32'(bus.wr_en), 0);
    checkHeld("midreset");
    @(negedge clk);
    reset = 1'b1;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk);
      #1;
      checkOutput("midreset.no_write", 32'(bus.wr_en), 0);
    end
`else
    // Unsupported op, then an ADD presented in the following cycle
    runOp(OP_MUL, 24'd1234, 24'd5678, 2'd3, 1'b0);
    runOp(OP_ADD, 24'd3, 24'd4, 2'd2, 1'b0);
`endif

    // Randomized operations against the reference model
    for (int i = 0; i < 20; i++) begin
      runOp(3'($urandom_range(0, 7)), W'($urandom), W'($urandom),
            AW'($urandom), 1'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
    $finish;
  end

endmodule

// File: doc/exec_unit.md
Name: exec_unit

Overview:
- Execute stage of the 24-bit datapath.
- Consumes the two register-file read operands, computes an ALU result, and drives the register-file write port (write/addr3/data3) back.
- Single-cycle logic/add/shift ops; iterative shift-add multiply via FSM.
- One operation in flight; busy/start handshake toward the decode/control stage.

Parameters:
- WIDTH, 24, operand/result width in bits.
- AW, 2, destination register address width (4 registers).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous active-low reset.
- start  in  1  request; accepted only when busy=0.
- op  in  3  opcode: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SHL, 110 SHR, 111 MUL.
- a  in  WIDTH  operand A (register file data1).
- b  in  WIDTH  operand B (register file data2).
- dst  in  AW  destination register index.
- busy  out  1  high while an op is in flight (state != IDLE).
- wr_en  out  1  one-cycle write strobe to register file.
- wr_addr  out  AW  write address (to addr3).
- wr_data  out  WIDTH  result (to data3).
- zero  out  1  registered: last result == 0.
- carry  out  1  registered: ADD carry-out / SUB borrow.
- illegal  out  1  one-cycle pulse: unsupported op accepted.

Behaviour:
- Reset (async, reset=0):
  - state=IDLE.
  - busy, wr_en, illegal, zero and carry = 0.
  - wr_addr = 0, wr_data = 0.
  - Internal operand, product and counter registers = 0.
- Reset mid-operation aborts the op; no write is issued.
- FSM states:
  - IDLE: on edge with start=1, capture a, b, op, dst.
    - op != MUL: compute result this edge, go to DONE.
    - op == MUL: clear product, load counter = WIDTH-1, go to MUL.
  - MUL: each cycle, if multiplier LSB=1 then product += multiplicand; multiplicand <<= 1; multiplier >>= 1.
    - When counter == 0, go to DONE; otherwise counter--.
    - Exactly WIDTH cycles in MUL.
  - DONE: wr_en=1, wr_addr=captured dst, wr_data=result; always return to IDLE next edge.
- Latency (start accepted at edge 0):
  - Single-cycle op: wr_en high in cycle 1.
  - MUL: wr_en high in cycle WIDTH+1 (cycle 25 at default).
  - Next start is accepted in the cycle after DONE at the earliest.
- Handshake:
  - start while busy=1 is ignored, not queued.
  - Operands must be valid only in the accept cycle; later changes on a, b or dst have no effect.
- Arithmetic (all results truncated to WIDTH bits):
  - ADD: carry = bit WIDTH of a+b.
  - SUB: a-b mod 2^WIDTH; carry = 1 iff a < b (unsigned borrow).
  - AND/OR/XOR: bitwise; carry = 0.
  - SHL/SHR: logical shift by b[4:0]; shift >= WIDTH gives 0; carry = 0.
  - MUL: low WIDTH bits of unsigned a*b; carry = 0.
- Flags:
  - zero and carry update in the same edge wr_data updates.
  - Held until the next result.
  - Not updated for illegal ops.
- wr_data and wr_addr hold their last value after DONE; only wr_en returns to 0.
- Simultaneous start and reset deassertion edge: reset dominates; start ignored until the first edge with reset=1.

Optional Feature:
- Macro: EXEC_MUL_EN.
- Defined: MUL state, counter and product datapath are present; op 111 behaves as above; illegal is never asserted.
- Undefined: no multiplier logic is built.
  - op 111 accepted in IDLE produces illegal=1 for one cycle (cycle 1).
  - No wr_en, state stays IDLE, busy stays 0.
  - Flags and wr_data unchanged.

Test Plan:
- Reset: hold reset=0 with random inputs -> busy=0, wr_en=0, wr_data=0, zero=0, carry=0; assert reset mid-MUL (cycle 10) -> no wr_en ever, busy=0 immediately.
- ADD overflow: a=24'hFFFFFF, b=24'h000001, dst=2 -> cycle 1: wr_en=1, wr_addr=2, wr_data=0, zero=1, carry=1.
- SUB borrow: a=5, b=7, dst=1 -> wr_data=24'hFFFFFE, carry=1, zero=0; then a=7, b=7 -> wr_data=0, zero=1, carry=0.
- Shifts: SHL a=24'h000001, b=23 -> 24'h800000; SHR a=24'h800000, b=24 -> 0; SHL b=31 -> 0.
- MUL (EXEC_MUL_EN defined): a=1234, b=5678, dst=3 -> busy high cycles 1-25, wr_en only in cycle 25, wr_data=7006652; a=24'hFFFFFF, b=2 -> 24'hFFFFFE; start pulsed in cycle 5 with other data -> ignored.
- MUL disabled (EXEC_MUL_EN undefined): op=111 -> illegal=1 in cycle 1, wr_en=0, busy=0; ADD 3+4 in cycle 2 -> wr_data=7 in cycle 3.
